// File: rtl/mem_stage.sv
// Memory stage of the five-stage pipeline: holds one instruction, waits for its
// data response, aligns load data and hands the result to write-back.
//
// state   | meaning
// IDLE    | no request outstanding
// WAIT    | request outstanding for the instruction held here
// DONE    | response arrived while WB stalled; data held in rdata_buf
// DISCARD | request outstanding for a flushed instruction; drop its response
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         es_to_ms_valid,
  input  logic [161:0] es_to_ms_bus,
  output logic         ms_allowin,
  input  logic         ws_allowin,
  output logic         ms_to_ws_valid,
  output logic [154:0] ms_to_ws_bus,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  input  logic         ws_handle_ex,
  output logic [3:0]   ms_fwd_we,
  output logic [4:0]   ms_fwd_dest,
  output logic [31:0]  ms_fwd_data,
  output logic         ms_fwd_stall,
  output logic         ms_ex_flush,
  output logic         ms_data_pending
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t         state;
  logic           ms_valid;
  logic [161:0]   ms_bus;
  logic [31:0]    rdata_buf;

  logic           ms_ex;
  logic [4:0]     ms_exccode;
  logic           ms_bd;
  logic [31:0]    ms_badvaddr;
  logic           ms_eret;
  logic           ms_mtc0;
  logic [7:0]     ms_cp0_addr;
  logic [31:0]    ms_cp0_wdata;
  logic           ms_res_from_cp0;
  logic           ms_res_from_mem;
  logic [2:0]     ms_ld_type;
  logic [1:0]     ms_addr_low;
  logic           ms_mem_req;
  logic [3:0]     ms_rf_we;
  logic [4:0]     ms_dest;
  logic [31:0]    ms_alu_result;
  logic [31:0]    ms_pc;

  logic           es_mem_req;
  logic           ms_ready_go;
  logic           es_accept;
  logic           ms_handoff;
  logic [31:0]    load_src;
  logic [7:0]     load_byte;
  logic [15:0]    load_half;
  logic [31:0]    load_data;
  logic [31:0]    final_result;
  logic [3:0]     out_rf_we;

  assign {ms_ex, ms_exccode, ms_bd, ms_badvaddr, ms_eret, ms_mtc0, ms_cp0_addr,
          ms_cp0_wdata, ms_res_from_cp0, ms_res_from_mem, ms_ld_type, ms_addr_low,
          ms_mem_req, ms_rf_we, ms_dest, ms_alu_result, ms_pc} = ms_bus;

  assign es_mem_req = es_to_ms_bus[73];

  assign ms_ready_go = !ms_mem_req || ms_ex || (state == S_DONE) ||
                       ((state == S_WAIT) && data_sram_data_ok);
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !ws_handle_ex;
  assign es_accept      = es_to_ms_valid && ms_allowin && !ws_handle_ex;
  assign ms_handoff     = ms_to_ws_valid && ws_allowin;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      ms_bus   <= '0;
    end else begin
      if (ws_handle_ex) begin
        ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (es_accept) begin
        ms_bus <= es_to_ms_bus;
      end
    end
  end

  // A flushed instruction whose request was already issued still owes us a
  // response, so flush-with-accept goes to DISCARD rather than IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      rdata_buf <= '0;
    end else if (ws_handle_ex) begin
      if (es_to_ms_valid && ms_allowin && es_mem_req) begin
        state <= S_DISCARD;
      end else begin
        case (state)
          S_WAIT:    state <= data_sram_data_ok ? S_IDLE : S_DISCARD;
          S_DISCARD: state <= data_sram_data_ok ? S_IDLE : S_DISCARD;
          default:   state <= S_IDLE;
        endcase
      end
    end else if (es_accept && es_mem_req) begin
      state <= S_WAIT;
    end else begin
      case (state)
        S_WAIT: begin
          if (data_sram_data_ok) begin
            if (ms_handoff) begin
              state <= S_IDLE;
            end else begin
              state     <= S_DONE;
              rdata_buf <= data_sram_rdata;
            end
          end
        end
        S_DONE: begin
          if (ms_handoff) begin
            state <= S_IDLE;
          end
        end
        S_DISCARD: begin
          if (data_sram_data_ok) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign load_src = (state == S_DONE) ? rdata_buf : data_sram_rdata;

  always_comb begin
    load_byte = load_src[7:0];
    case (ms_addr_low)
      2'd0: load_byte = load_src[7:0];
      2'd1: load_byte = load_src[15:8];
      2'd2: load_byte = load_src[23:16];
      2'd3: load_byte = load_src[31:24];
      default: load_byte = load_src[7:0];
    endcase
  end

  assign load_half = ms_addr_low[1] ? load_src[31:16] : load_src[15:0];

  always_comb begin
    load_data = load_src;
    case (ms_ld_type)
      3'd1:    load_data = {{24{load_byte[7]}}, load_byte};
      3'd2:    load_data = {24'd0, load_byte};
      3'd3:    load_data = {{16{load_half[15]}}, load_half};
      3'd4:    load_data = {16'd0, load_half};
      default: load_data = load_src;
    endcase
  end

  assign final_result = ms_res_from_mem ? load_data : ms_alu_result;
  assign out_rf_we    = ms_ex ? 4'd0 : ms_rf_we;

  assign ms_to_ws_bus = {ms_ex, ms_exccode, ms_bd, ms_badvaddr, ms_eret, ms_mtc0,
                         ms_cp0_addr, ms_cp0_wdata, ms_res_from_cp0, out_rf_we,
                         ms_dest, final_result, ms_pc};

  assign ms_fwd_we       = ms_valid ? out_rf_we : 4'd0;
  assign ms_fwd_dest     = ms_dest;
  assign ms_fwd_data     = final_result;
  assign ms_fwd_stall    = ms_valid && ms_res_from_mem && !ms_ready_go;
  assign ms_ex_flush     = ms_valid && (ms_ex || ms_eret);
  assign ms_data_pending = (state == S_WAIT) || (state == S_DISCARD);

endmodule
